// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs and stage enable/flush strobes.
// master = pipeline datapath side, slave = hazard controller.
interface pipe_hazard_ctrl_if;
  logic       run;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_memread;
  logic [4:0] ex_rt;
  logic       br_taken;
  logic       halt_req;
  logic       dmem_req;
  logic       dmem_ready;
  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       memwb_en;
  logic       ifid_wipe;
  logic       idex_wipe;
  logic       exmem_wipe;
  logic       memwb_wipe;
  logic       halted;
  logic       timeout_err;

  modport master (
    output run, id_rs, id_rt, id_uses_rt,
    output ex_memread, ex_rt, br_taken,
    output halt_req, dmem_req, dmem_ready,
    input  pc_en, ifid_en, idex_en,
    input  exmem_en, memwb_en,
    input  ifid_wipe, idex_wipe,
    input  exmem_wipe, memwb_wipe,
    input  halted, timeout_err
  );

  modport slave (
    input  run, id_rs, id_rt, id_uses_rt,
    input  ex_memread, ex_rt, br_taken,
    input  halt_req, dmem_req, dmem_ready,
    output pc_en, ifid_en, idex_en,
    output exmem_en, memwb_en,
    output ifid_wipe, idex_wipe,
    output exmem_wipe, memwb_wipe,
    output halted, timeout_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline enable/flush sequencer.
// Define HAZARD_PERF_EN to add stall/flush/memwait counters.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int DRAIN_CYCLES   = 4,
  parameter int CNT_W          = 32
) (
  input  logic clk,
  input  logic reset,
  pipe_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
`endif
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    S_RUN, S_MEM_WAIT, S_DRAIN, S_HALT
  } state_t;

  state_t        r_state, w_next;
  logic [WW-1:0] r_wait, w_wait_nxt;
  logic [DW-1:0] r_drain, w_drain_nxt;
  logic          r_err, w_err_nxt;
  logic [4:0]    w_en;
  logic [3:0]    w_wipe;
  logic          w_load_use;
  logic          w_hold;
  logic          w_ev_lu, w_ev_br, w_ev_stall;

  assign w_load_use = hz.ex_memread && (hz.ex_rt != 5'd0) &&
                      ((hz.ex_rt == hz.id_rs) ||
                       (hz.id_uses_rt && hz.ex_rt == hz.id_rt));

  // RUN stalls only on an active request; MEM_WAIT holds until ready.
  assign w_hold = (r_state == S_MEM_WAIT) ? !hz.dmem_ready
                : (hz.dmem_req && !hz.dmem_ready);

  always_comb begin
    w_en        = 5'b11111;
    w_wipe      = 4'b0000;
    w_next      = r_state;
    w_wait_nxt  = r_wait;
    w_drain_nxt = r_drain;
    w_err_nxt   = r_err;
    w_ev_lu     = 1'b0;
    w_ev_br     = 1'b0;
    w_ev_stall  = 1'b0;
    if (reset) begin
      w_en   = 5'b00000;
      w_wipe = 4'b1111;
    end else if (r_state == S_HALT || !hz.run) begin
      w_en = 5'b00000;
    end else if (w_hold) begin
      w_en       = 5'b00001;
      w_wipe     = 4'b0001;
      w_ev_stall = 1'b1;
      if (r_state == S_RUN) begin
        w_next     = S_MEM_WAIT;
        w_wait_nxt = WW'(1);
      end else if (r_wait == WW'(TIMEOUT_CYCLES)) begin
        w_next    = S_HALT;
        w_err_nxt = 1'b1;
      end else begin
        w_wait_nxt = r_wait + WW'(1);
      end
    end else if (r_state == S_DRAIN) begin
      w_en       = 5'b01111;
      w_wipe     = 4'b1000;
      w_wait_nxt = '0;
      if (r_drain == DW'(DRAIN_CYCLES - 1))
        w_next = S_HALT;
      else
        w_drain_nxt = r_drain + DW'(1);
    end else begin
      w_next     = S_RUN;
      w_wait_nxt = '0;
      if (hz.br_taken) begin
        w_wipe  = 4'b1100;
        w_ev_br = 1'b1;
      end else if (w_load_use) begin
        w_en    = 5'b00111;
        w_wipe  = 4'b0100;
        w_ev_lu = 1'b1;
      end else if (hz.halt_req) begin
        w_next      = S_DRAIN;
        w_drain_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_wait  <= '0;
      r_drain <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_nxt;
      r_drain <= w_drain_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign {hz.pc_en, hz.ifid_en, hz.idex_en,
          hz.exmem_en, hz.memwb_en} = w_en;
  assign {hz.ifid_wipe, hz.idex_wipe,
          hz.exmem_wipe, hz.memwb_wipe} = w_wipe;
  assign hz.halted      = (r_state == S_HALT);
  assign hz.timeout_err = r_err;

`ifdef HAZARD_PERF_EN
  // Event strobes are already gated off by reset, run=0 and HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      memwait_cnt <= '0;
    end else begin
      stall_cnt   <= stall_cnt + CNT_W'(w_ev_lu);
      flush_cnt   <= flush_cnt + CNT_W'(w_ev_br);
      memwait_cnt <= memwait_cnt + CNT_W'(w_ev_stall);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors for the hazard sequencer.
// Runs with TIMEOUT_CYCLES=4, DRAIN_CYCLES=4.
module tb_pipe_hazard_ctrl;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl #(
    .TIMEOUT_CYCLES(4),
    .DRAIN_CYCLES(4),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hz(hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] EN_ADV = 5'b11111;
  localparam logic [4:0] EN_STL = 5'b00001;
  localparam logic [4:0] EN_LU  = 5'b00111;
  localparam logic [4:0] EN_DRN = 5'b01111;
  localparam logic [4:0] EN_OFF = 5'b00000;

  task automatic chk(string tag, logic [10:0] got,
                     logic [10:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] obs();
    return {hz.pc_en, hz.ifid_en, hz.idex_en,
            hz.exmem_en, hz.memwb_en,
            hz.ifid_wipe, hz.idex_wipe,
            hz.exmem_wipe, hz.memwb_wipe,
            hz.halted, hz.timeout_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(string tag, logic [4:0] en,
                      logic [3:0] wp, logic h, logic e);
    #2;
    chk(tag, obs(), {en, wp, h, e});
  endtask

  task automatic idle();
    hz.run        = 1'b1;
    hz.id_rs      = 5'd1;
    hz.id_rt      = 5'd2;
    hz.id_uses_rt = 1'b0;
    hz.ex_memread = 1'b0;
    hz.ex_rt      = 5'd0;
    hz.br_taken   = 1'b0;
    hz.halt_req   = 1'b0;
    hz.dmem_req   = 1'b0;
    hz.dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    idle();
    tick();
    look("reset_out", EN_OFF, 4'b1111, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    look("run_idle", EN_ADV, 4'b0000, 1'b0, 1'b0);
    tick();

    hz.ex_memread = 1'b1; hz.ex_rt = 5'd5; hz.id_rs = 5'd5;
    look("lu_rs", EN_LU, 4'b0100, 1'b0, 1'b0);
    tick();
    hz.ex_memread = 1'b0;
    look("lu_after", EN_ADV, 4'b0000, 1'b0, 1'b0);
    tick();

    hz.ex_memread = 1'b1; hz.ex_rt = 5'd0; hz.id_rs = 5'd0;
    look("lu_zero", EN_ADV, 4'b0000, 1'b0, 1'b0);
    tick();
    hz.ex_rt = 5'd7; hz.id_rs = 5'd3; hz.id_rt = 5'd7;
    hz.id_uses_rt = 1'b1;
    look("lu_rt", EN_LU, 4'b0100, 1'b0, 1'b0);
    tick();
    hz.id_uses_rt = 1'b0;
    look("lu_rt_unused", EN_ADV, 4'b0000, 1'b0, 1'b0);
    tick();

    hz.id_uses_rt = 1'b1; hz.br_taken = 1'b1; hz.halt_req = 1'b1;
    look("br_beats_lu", EN_ADV, 4'b1100, 1'b0, 1'b0);
    tick();
    idle();
    look("br_no_drain", EN_ADV, 4'b0000, 1'b0, 1'b0);
    tick();

    hz.dmem_req = 1'b1; hz.br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      look($sformatf("mw_stall%0d", i), EN_STL, 4'b0001,
           1'b0, 1'b0);
      tick();
    end
    hz.dmem_ready = 1'b1;
    look("mw_ready_br", EN_ADV, 4'b1100, 1'b0, 1'b0);
    tick();
    idle();
    look("mw_back_run", EN_ADV, 4'b0000, 1'b0, 1'b0);
    tick();

    hz.dmem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      look($sformatf("to_stall%0d", i), EN_STL, 4'b0001,
           1'b0, 1'b0);
      tick();
    end
    look("to_halted", EN_OFF, 4'b0000, 1'b1, 1'b1);
    tick();
    look("to_sticky", EN_OFF, 4'b0000, 1'b1, 1'b1);
    reset = 1'b1;
    look("to_rst_out", EN_OFF, 4'b1111, 1'b1, 1'b1);
    tick();
    reset = 1'b0;
    idle();
    look("to_rst_clr", EN_ADV, 4'b0000, 1'b0, 1'b0);
    tick();

    hz.dmem_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      look($sformatf("fz_pre%0d", i), EN_STL, 4'b0001,
           1'b0, 1'b0);
      tick();
    end
    hz.run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      look($sformatf("fz_off%0d", i), EN_OFF, 4'b0000,
           1'b0, 1'b0);
      tick();
    end
    hz.run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      look($sformatf("fz_post%0d", i), EN_STL, 4'b0001,
           1'b0, 1'b0);
      tick();
    end
    look("fz_timeout", EN_OFF, 4'b0000, 1'b1, 1'b1);
    do_reset();

    hz.halt_req = 1'b1;
    look("hl_req", EN_ADV, 4'b0000, 1'b0, 1'b0);
    tick();
    hz.halt_req = 1'b0; hz.br_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      look($sformatf("hl_drain%0d", i), EN_DRN, 4'b1000,
           1'b0, 1'b0);
      tick();
    end
    hz.br_taken = 1'b0;
    look("hl_halted", EN_OFF, 4'b0000, 1'b1, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    look("hl_rst_run", EN_ADV, 4'b0000, 1'b0, 1'b0);
    tick();

    hz.halt_req = 1'b1;
    look("rd_req", EN_ADV, 4'b0000, 1'b0, 1'b0);
    tick();
    hz.halt_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      look($sformatf("rd_drain%0d", i), EN_DRN, 4'b1000,
           1'b0, 1'b0);
      tick();
    end
    reset = 1'b1;
    look("rd_rst_out", EN_OFF, 4'b1111, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    look("rd_rst_run", EN_ADV, 4'b0000, 1'b0, 1'b0);
    tick();

    hz.halt_req = 1'b1;
    look("dd_req", EN_ADV, 4'b0000, 1'b0, 1'b0);
    tick();
    hz.halt_req = 1'b0;
    look("dd_drain0", EN_DRN, 4'b1000, 1'b0, 1'b0);
    tick();
    hz.dmem_req = 1'b1;
    look("dd_stall", EN_STL, 4'b0001, 1'b0, 1'b0);
    tick();
    hz.dmem_req = 1'b0;
    for (int i = 1; i < 4; i++) begin
      look($sformatf("dd_drain%0d", i), EN_DRN, 4'b1000,
           1'b0, 1'b0);
      tick();
    end
    look("dd_halted", EN_OFF, 4'b0000, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline: IF, IF/ID, ID/EX, EX/MEM, MEM/WB.
- Produces the per-stage enable (`*_en`, drives the register "power" input) and flush (`*_wipe`) strobes for every pipeline register, plus `pc_en`.
- Resolves load-use hazards, taken-branch flushes, data-memory wait states, and a halt/drain sequence.
- State is updated on the rising edge of `clk`. Outputs settle combinationally before the falling edge, which is when the pipeline registers capture.

Parameters:
- TIMEOUT_CYCLES, 64: max consecutive dmem wait cycles before fatal timeout; counter width is clog2(TIMEOUT_CYCLES+1).
- DRAIN_CYCLES, 4: advancing cycles spent draining before HALT.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  system clock; state updates on posedge.
- reset  in  1  reset, synchronous, active-high.
- run  in  1  global run; 0 freezes the whole pipeline.
- id_rs  in  5  ID-stage source register rs.
- id_rt  in  5  ID-stage source register rt.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_memread  in  1  EX-stage instruction is a load.
- ex_rt  in  5  EX-stage load destination register.
- br_taken  in  1  branch/jump resolved taken in EX.
- halt_req  in  1  ID-stage instruction is halt/syscall.
- dmem_req  in  1  MEM stage has an active data-memory access.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables.
- ifid_wipe, idex_wipe, exmem_wipe, memwb_wipe  out  1 each  register flushes.
- halted  out  1  core halted.
- timeout_err  out  1  sticky dmem timeout flag.

Behaviour:
- States: RUN, MEM_WAIT, DRAIN, HALT.
- Reset (reset=1 at posedge):
  - state=RUN, wait counter=0, drain counter=0, halted=0, timeout_err=0.
  - While reset is high, combinational outputs are all en=0 and all wipe=1, overriding every other rule.
- Default "advance" pattern: all en=1, all wipe=0.
- run=0 in any state except HALT: all en=0, all wipe=0. No state, counter or perf-counter change. Reset still applies.
- load_use = ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- RUN, evaluated in strict priority order:
  1. dmem_req & !dmem_ready → stall pattern, next=MEM_WAIT, wait counter=1.
     - Stall pattern: pc/ifid/idex/exmem en=0; memwb_en=1; memwb_wipe=1 (bubble into WB).
  2. br_taken → advance, except ifid_wipe=1 and idex_wipe=1. halt_req is ignored because it is wrong-path.
  3. load_use → pc_en=0, ifid_en=0, idex_wipe=1; other stages advance. This lasts exactly one cycle because the bubble clears ex_memread.
  4. halt_req → advance, next=DRAIN, drain counter=0.
  5. Otherwise → advance.
- MEM_WAIT:
  - dmem_ready=0: stall pattern, wait counter +1.
  - If the wait counter already equals TIMEOUT_CYCLES → next=HALT, timeout_err=1.
  - dmem_ready=1: evaluate RUN rules 2-5 this cycle; next=RUN (or DRAIN per rule 4); wait counter=0.
- DRAIN:
  - Outputs: pc_en=0, ifid_en=1, ifid_wipe=1; other stages advance.
  - br_taken, load_use and halt_req are ignored.
  - dmem_req & !dmem_ready applies the stall pattern and freezes the drain counter; timeout counting is as in MEM_WAIT and can also reach HALT.
  - Each advancing cycle increments the drain counter. When the counter reaches DRAIN_CYCLES-1 on an advancing cycle → next=HALT.
- HALT:
  - All en=0, all wipe=0, halted=1.
  - Exit only by reset. timeout_err holds until reset.
- Simultaneous events:
  - dmem stall beats branch: the branch is re-presented next cycle because EX is held.
  - Branch beats load_use and beats halt_req.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds three outputs (CNT_W bits each): stall_cnt, flush_cnt, memwait_cnt.
  - stall_cnt counts load-use cycles.
  - flush_cnt counts br_taken flush cycles.
  - memwait_cnt counts cycles with the stall pattern.
  - All three reset to 0, wrap modulo 2^CNT_W, and freeze when run=0 or in HALT.
- When undefined, these ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Load-use: ex_memread=1, ex_rt=5, id_rs=5 for one cycle → pc_en=0, ifid_en=0, idex_wipe=1 for that cycle; next cycle (ex_memread=0) all en=1, all wipe=0.
- Zero register: ex_rt=0, id_rs=0, ex_memread=1 → no stall; all en=1.
- Branch plus load-use same cycle: br_taken=1 → ifid_wipe=1, idex_wipe=1, pc_en=1; no load-use stall.
- Memory wait: dmem_req=1 with dmem_ready low for 3 cycles, then high → 3 cycles of stall pattern with memwb_wipe=1, then advance; state returns to RUN. With TIMEOUT_CYCLES=4 and ready held low for 5 cycles → timeout_err=1, halted=1 after the 5th cycle.
- Halt: halt_req=1 in RUN → 4 cycles of pc_en=0 and ifid_wipe=1, then halted=1 with all en=0; a later reset pulse → halted=0, state=RUN.
- Freeze and reset priority: run=0 mid-MEM_WAIT → all en=0 and wait counter unchanged; reset=1 mid-DRAIN → next cycle state=RUN and all counters 0.
